// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The optional duty-threshold feature is enabled with CLKDIV_DUTY_EN.
package clk_div_pkg;

  localparam int DEF_W         = 29;
  localparam int DEF_DIV_RESET = 50000000;
  localparam int HALT_DIV      = 0;

  // Channel-select width, never narrower than one bit even for a single channel.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow divisor, pending flag, period counter and
// registered q/tick outputs. CLKDIV_DUTY_EN adds a programmable high threshold.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEF_DIV = DEF_DIV_RESET
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         ldDiv_i,
`ifdef CLKDIV_DUTY_EN
  input  logic         ldThr_i,
`endif
  input  logic [W-1:0] data_i,
  output logic         q_o,
  output logic         tick_o
);

  localparam logic [W-1:0] RESET_DIV = W'(DEF_DIV);
  localparam logic [W-1:0] HALT      = W'(HALT_DIV);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pend_q, pend_d;
  logic         q_q, q_d;
  logic         tick_q, tick_d;
  logic         transfer;
  logic         running;
  logic [W-1:0] thrEff;
`ifdef CLKDIV_DUTY_EN
  localparam logic [W-1:0] RESET_THR = W'(DEF_DIV >> 1);
  logic [W-1:0] thr_q, thr_d;
  logic [W-1:0] thrShadow_q, thrShadow_d;
`endif

  // Outputs are computed from the next count and next divisor so they line up
  // with the counter value that becomes visible after the edge.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    transfer = 1'b0;
`ifdef CLKDIV_DUTY_EN
    thr_d       = thr_q;
    thrShadow_d = thrShadow_q;
`endif
    if (en_i && (div_q != HALT)) begin
      if (cnt_q == div_q - W'(1)) begin
        cnt_d    = '0;
        transfer = pend_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      // Halted or disabled: a pending value loads at once and restarts the period.
      cnt_d    = '0;
      transfer = pend_q;
    end
    if (transfer) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
      thr_d = thrShadow_q;
`endif
    end
    if (ldDiv_i) begin
      shadow_d = data_i;
      pend_d   = 1'b1;
    end
`ifdef CLKDIV_DUTY_EN
    if (ldThr_i) begin
      thrShadow_d = data_i;
      pend_d      = 1'b1;
    end
    thrEff = thr_d;
`else
    thrEff = div_d >> 1;
`endif
    running = en_i && (div_d != HALT);
    q_d     = running && (cnt_d >= thrEff);
    tick_d  = running && (cnt_d == div_d - W'(1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      div_q    <= RESET_DIV;
      shadow_q <= RESET_DIV;
      pend_q   <= 1'b0;
      q_q      <= 1'b0;
      tick_q   <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      thr_q       <= RESET_THR;
      thrShadow_q <= RESET_THR;
`endif
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      q_q      <= q_d;
      tick_q   <= tick_d;
`ifdef CLKDIV_DUTY_EN
      thr_q       <= thr_d;
      thrShadow_q <= thrShadow_d;
`endif
    end
  end

  assign q_o    = q_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider top: decodes register writes into
// per-channel load strobes. CLKDIV_DUTY_EN adds wr_sel for threshold writes.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int W       = DEF_W,
  parameter int DEF_DIV = DEF_DIV_RESET
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH-1:0]            en,
  input  logic                      wr_en,
  input  logic [chWidth(NCH)-1:0]   wr_ch,
  input  logic [W-1:0]              wr_data,
`ifdef CLKDIV_DUTY_EN
  input  logic                      wr_sel,
`endif
  output logic [NCH-1:0]            q,
  output logic [NCH-1:0]            tick
);

  logic [NCH-1:0] ldDiv;
`ifdef CLKDIV_DUTY_EN
  logic [NCH-1:0] ldThr;
`endif

  // Writes to channel numbers beyond NCH match no strobe and are dropped.
  always_comb begin
    ldDiv = '0;
`ifdef CLKDIV_DUTY_EN
    ldThr = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && (int'(wr_ch) == i)) begin
`ifdef CLKDIV_DUTY_EN
        if (wr_sel) ldThr[i] = 1'b1;
        else        ldDiv[i] = 1'b1;
`else
        ldDiv[i] = 1'b1;
`endif
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : gChan
    clk_div_chan #(
      .W      (W),
      .DEF_DIV(DEF_DIV)
    ) uChan (
      .clk_i  (clk),
      .reset_i(reset),
      .en_i   (en[i]),
      .ldDiv_i(ldDiv[i]),
`ifdef CLKDIV_DUTY_EN
      .ldThr_i(ldThr[i]),
`endif
      .data_i (wr_data),
      .q_o    (q[i]),
      .tick_o (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random writes
// and enables against a per-channel period model. Honours CLKDIV_DUTY_EN.
module tb_clk_div_multi;

  localparam int NCH     = 5;
  localparam int W       = 8;
  localparam int DEF_DIV = 4;
  localparam int CH_W    = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  en;
  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [W-1:0]    wr_data;
  logic            selBit;
  logic [NCH-1:0]  q;
  logic [NCH-1:0]  tick;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: period length, shadow, pending, position within period, threshold.
  int mD[NCH], mS[NCH], mPos[NCH], mT[NCH], mTS[NCH];
  bit mP[NCH];
  logic [NCH-1:0] expQ, expTick;

  clk_div_multi #(
    .NCH    (NCH),
    .W      (W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_data(wr_data),
`ifdef CLKDIV_DUTY_EN
    .wr_sel (selBit),
`endif
    .q      (q),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mD[c] = DEF_DIV; mS[c] = DEF_DIV; mP[c] = 0; mPos[c] = 0;
      mT[c] = DEF_DIV / 2; mTS[c] = DEF_DIV / 2;
    end
    expQ = '0; expTick = '0;
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic modelStep();
    if (reset) begin
      modelReset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit hit, xfer, running;
      int thr;
      hit  = wr_en && (int'(wr_ch) == c);
      xfer = 0;
      if (en[c] && mD[c] != 0) begin
        if (mPos[c] == mD[c] - 1) begin
          mPos[c] = 0;
          xfer = mP[c];
        end else begin
          mPos[c]++;
        end
      end else begin
        mPos[c] = 0;
        xfer = mP[c];
      end
      if (xfer) begin
        mD[c] = mS[c]; mT[c] = mTS[c]; mP[c] = 0;
      end
      if (hit) begin
        if (selBit) mTS[c] = int'(wr_data);
        else        mS[c]  = int'(wr_data);
        mP[c] = 1;
      end
      running = en[c] && (mD[c] != 0);
`ifdef CLKDIV_DUTY_EN
      thr = mT[c];
`else
      thr = mD[c] / 2;
`endif
      expQ[c]    = running && (mPos[c] >= thr);
      expTick[c] = running && (mPos[c] == mD[c] - 1);
    end
  endtask

  task automatic applyStimulus();
    modelStep();
    @(negedge clk);
    checkOutput("q", 32'(q), 32'(expQ));
    checkOutput("tick", 32'(tick), 32'(expTick));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic writeReg(input int ch, input int data, input bit sel);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_data = W'(data); selBit = sel;
    applyStimulus();
    wr_en = 1'b0; selBit = 1'b0;
  endtask

  // Step until the model reports the wanted position on a channel, bounded.
  task automatic waitPos(input int ch, input int pos, input int divisor, input string tag);
    int n = 0;
    while (!(mPos[ch] == pos && mD[ch] == divisor) && n < 40) begin
      applyStimulus();
      n++;
    end
    if (n >= 40) checkOutput(tag, 32'(n), 32'(0));
  endtask

  initial begin
    reset = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_data = '0; selBit = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("resetQ", 32'(q), 32'(0));
    checkOutput("resetTick", 32'(tick), 32'(0));

    reset = 1'b0;
    runCycles(2);
    checkOutput("disabledQ", 32'(q), 32'(0));

    // Default divisor 4: q low two cycles then high two, tick on the last.
    en = '1;
    for (int k = 0; k < 8; k++) begin
      int cnt;
      applyStimulus();
      cnt = (k + 1) % 4;
      checkOutput("ch0Q", 32'(q[0]), 32'(cnt >= 2));
      checkOutput("ch0Tick", 32'(tick[0]), 32'(cnt == 3));
    end

    writeReg(1, 5, 0);
    runCycles(15);

    waitPos(2, 1, 4, "waitCh2");
    writeReg(2, 8, 0);
    runCycles(20);

    writeReg(3, 6, 0);
    waitPos(3, 3, 4, "waitCh3Wrap");
    writeReg(3, 3, 0);
    runCycles(20);

    writeReg(0, 0, 0);
    runCycles(8);
    checkOutput("ch0Halted", 32'({q[0], tick[0]}), 32'(0));
    writeReg(0, 3, 0);
    runCycles(9);

    writeReg(4, 6, 0);
    waitPos(4, 2, 6, "waitCh4");
    en[4] = 1'b0;
    applyStimulus();
    checkOutput("enDrop", 32'({q[4], tick[4]}), 32'(0));
    en[4] = 1'b1;
    runCycles(12);

    writeReg(4, 1, 0);
    runCycles(8);

`ifdef CLKDIV_DUTY_EN
    writeReg(1, 10, 0);
    writeReg(1, 7, 1);
    runCycles(25);
`endif

    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 31) == 0) en[c] = ~en[c];
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_ch   = CH_W'($urandom_range(0, 7));
      wr_data = W'($urandom_range(0, 9));
      selBit  = 1'b0;
`ifdef CLKDIV_DUTY_EN
      selBit  = ($urandom_range(0, 1) == 1);
`endif
      applyStimulus();
    end
    wr_en = 1'b0; selBit = 1'b0; en = '1;
    runCycles(10);

    // Asynchronous reset away from the clock edge, with a write that must be lost.
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncQ", 32'(q), 32'(0));
    checkOutput("asyncTick", 32'(tick), 32'(0));
    modelReset();
    @(negedge clk);
    wr_en = 1'b1; wr_ch = CH_W'(1); wr_data = W'(7);
    applyStimulus();
    reset = 1'b0; wr_en = 1'b0;
    runCycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
